reg_file_mp: RTL and testbench

- Parametrised multi-read-port register file; successor to the 16x16 CPU register file.
- Configurable data width, register count and read-port count; register 0 hardwired to zero.
- Adds a sequential clear engine (reset or on-demand) with a busy indication.
- Sits between decode (read selects) and writeback (write port) in the CPU datapath.

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_file_mp_read_port.sv | 37 +++
 rtl/reg_file_mp.sv | 115 +++++++++++
 tb/tb_reg_file_mp.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
package reg_file_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  function automatic int rf_aw(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/reg_file_mp_read_port.sv
// One combinational read mux; optional same-cycle write forwarding under REG_FILE_MP_BYPASS_EN.
module rf_read_port #(
  parameter int DW    = 16,
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic [AW-1:0]       idx_i,
  input  logic [NREGS*DW-1:0] mem_flat_i,
  input  logic                byp_vld_i,
  input  logic [AW-1:0]       byp_idx_i,
  input  logic [DW-1:0]       byp_data_i,
  input  logic                busy_i,
  output logic [DW-1:0]       data_o
);

  logic [DW-1:0] stored;

  assign stored = mem_flat_i[idx_i*DW +: DW];

`ifdef REG_FILE_MP_BYPASS_EN
  always_comb begin
    data_o = stored;
    if (byp_vld_i && (idx_i == byp_idx_i)) data_o = byp_data_i;
    // busy and index 0 win over forwarding
    if (busy_i || (idx_i == '0)) data_o = '0;
  end
`else
  logic unused_byp;
  assign unused_byp = ^{byp_vld_i, byp_idx_i, byp_data_i};

  always_comb begin
    data_o = stored;
    if (busy_i || (idx_i == '0)) data_o = '0;
  end
`endif

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with a sequential clear engine.
// Optional write-to-read forwarding: define REG_FILE_MP_BYPASS_EN.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DW    = 16,
  parameter int NREGS = 16,
  parameter int NRD   = 2,
  localparam int AW   = rf_aw(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [AW-1:0]     wsel,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     wcur,
  input  logic [NRD*AW-1:0] rsel,
  output logic [NRD*DW-1:0] rdata,
  output logic              busy
);

  // state      | meaning
  // RF_IDLE    | normal read/write operation
  // RF_CLEAR   | zeroing register cnt_q, one per cycle, writes discarded

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

  rf_state_t     state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic [DW-1:0]       mem_q [NREGS];
  logic [NREGS*DW-1:0] mem_flat;
  logic                wr_en;
  logic                clr_wr;

  assign busy   = (state_q == RF_CLEAR);
  assign wr_en  = !rst && (state_q == RF_IDLE) && we && (wsel != '0);
  assign clr_wr = !rst && (state_q == RF_CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_IDLE: begin
        if (clr) begin
          state_d = RF_CLEAR;
          cnt_d   = AW'(1);
        end
      end
      RF_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == LAST_IDX) state_d = RF_IDLE;
      end
      default: begin
        state_d = RF_CLEAR;
        cnt_d   = AW'(1);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_CLEAR;
      cnt_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage is never bulk-reset; the clear pass zeroes it one entry at a time.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wsel] <= wdata;
    end else if (clr_wr) begin
      mem_q[cnt_q] <= '0;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_flat
    assign mem_flat[i*DW +: DW] = mem_q[i];
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rf_read_port #(
      .DW   (DW),
      .NREGS(NREGS),
      .AW   (AW)
    ) u_rd (
      .idx_i     (rsel[k*AW +: AW]),
      .mem_flat_i(mem_flat),
      .byp_vld_i (wr_en),
      .byp_idx_i (wsel),
      .byp_data_i(wdata),
      .busy_i    (busy),
      .data_o    (rdata[k*DW +: DW])
    );
  end

  rf_read_port #(
    .DW   (DW),
    .NREGS(NREGS),
    .AW   (AW)
  ) u_wcur (
    .idx_i     (wsel),
    .mem_flat_i(mem_flat),
    .byp_vld_i (wr_en),
    .byp_idx_i (wsel),
    .byp_data_i(wdata),
    .busy_i    (busy),
    .data_o    (wcur)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: default 16x16x2 instance plus a 32x32x3 instance.
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  wsel = '0;
  logic [15:0] wdata = '0;
  logic [15:0] wcur;
  logic [7:0]  rsel = '0;
  logic [31:0] rdata;
  logic        busy;

  logic        clr_b = 1'b0;
  logic        we_b = 1'b0;
  logic [4:0]  wsel_b = '0;
  logic [31:0] wdata_b = '0;
  logic [31:0] wcur_b;
  logic [14:0] rsel_b = '0;
  logic [95:0] rdata_b;
  logic        busy_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  reg_file_mp #(.DW(16), .NREGS(16), .NRD(2)) u_dut_a (
    .clk(clk), .rst(rst), .clr(clr), .we(we), .wsel(wsel), .wdata(wdata),
    .wcur(wcur), .rsel(rsel), .rdata(rdata), .busy(busy)
  );

  reg_file_mp #(.DW(32), .NREGS(32), .NRD(3)) u_dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .we(we_b), .wsel(wsel_b), .wdata(wdata_b),
    .wcur(wcur_b), .rsel(rsel_b), .rdata(rdata_b), .busy(busy_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [3:0] idx, input logic [15:0] val);
    we = 1'b1; wsel = idx; wdata = val;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    int na, nb, zero_bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rsel = {4'd1, 4'd5};
    wsel = 4'd3;
    na = 0; nb = 0; zero_bad = 0;
    for (int i = 0; i < 100 && (busy || busy_b); i++) begin
      if (busy) begin
        na++;
        if (rdata !== 32'h0 || wcur !== 16'h0) zero_bad++;
      end
      if (busy_b) nb++;
      tick();
    end
    total++;
    if (na !== 15) begin bad++; $display("FAIL reset_busy_a: got %0d cycles, want 15", na); end
    total++;
    if (nb !== 31) begin bad++; $display("FAIL reset_busy_b: got %0d cycles, want 31", nb); end
    total++;
    if (zero_bad !== 0) begin bad++; $display("FAIL reset_forced_zero: %0d nonzero busy cycles, want 0", zero_bad); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_idle: busy=%b want 0", busy); end
    zero_bad = 0;
    for (int i = 0; i < 16; i++) begin
      rsel = {4'(15 - i), 4'(i)};
      #1;
      if (rdata !== 32'h0) zero_bad++;
    end
    total++;
    if (zero_bad !== 0) begin bad++; $display("FAIL reset_all_zero: %0d nonzero reads, want 0", zero_bad); end
  endtask

  task automatic test_basic();
    write_a(4'd5, 16'hBEEF);
    write_a(4'd9, 16'h1234);
    rsel = {4'd9, 4'd5};
    wsel = 4'd5;
    #1;
    total++;
    if (rdata[15:0] !== 16'hBEEF) begin bad++; $display("FAIL basic_r5: got %h want beef", rdata[15:0]); end
    total++;
    if (rdata[31:16] !== 16'h1234) begin bad++; $display("FAIL basic_r9: got %h want 1234", rdata[31:16]); end
    total++;
    if (wcur !== 16'hBEEF) begin bad++; $display("FAIL basic_wcur: got %h want beef", wcur); end
    write_a(4'd0, 16'hFFFF);
    rsel = {4'd5, 4'd0};
    wsel = 4'd0;
    #1;
    total++;
    if (rdata !== {16'hBEEF, 16'h0000}) begin bad++; $display("FAIL basic_r0: got %h want beef0000", rdata); end
    total++;
    if (wcur !== 16'h0) begin bad++; $display("FAIL basic_wcur_r0: got %h want 0000", wcur); end
  endtask

  task automatic test_same_cycle();
    logic [15:0] exp;
    write_a(4'd3, 16'h0001);
    we = 1'b1; wsel = 4'd3; wdata = 16'hA5A5; rsel = {4'd9, 4'd3};
    #1;
`ifdef REG_FILE_MP_BYPASS_EN
    exp = 16'hA5A5;
`else
    exp = 16'h0001;
`endif
    total++;
    if (rdata[15:0] !== exp) begin bad++; $display("FAIL same_cycle_rd: got %h want %h", rdata[15:0], exp); end
    total++;
    if (wcur !== exp) begin bad++; $display("FAIL same_cycle_wcur: got %h want %h", wcur, exp); end
    total++;
    if (rdata[31:16] !== 16'h1234) begin bad++; $display("FAIL same_cycle_other: got %h want 1234", rdata[31:16]); end
    tick();
    we = 1'b0;
    #1;
    total++;
    if (rdata[15:0] !== 16'hA5A5) begin bad++; $display("FAIL same_cycle_next: got %h want a5a5", rdata[15:0]); end
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 100 && busy_b; i++) tick();
    we_b = 1'b1; wsel_b = 5'd31; wdata_b = 32'hDEADBEEF;
    tick();
    we_b = 1'b0;
    rsel_b = {5'd31, 5'd31, 5'd31};
    #1;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (rdata_b[k*32 +: 32] !== 32'hDEADBEEF) begin
        bad++; $display("FAIL sweep_port%0d: got %h want deadbeef", k, rdata_b[k*32 +: 32]);
      end
    end
    total++;
    if (wcur_b !== 32'hDEADBEEF) begin bad++; $display("FAIL sweep_wcur: got %h want deadbeef", wcur_b); end
    rsel_b = {5'd31, 5'd0, 5'd30};
    #1;
    total++;
    if (rdata_b !== {32'hDEADBEEF, 64'h0}) begin bad++; $display("FAIL sweep_mixed: got %h", rdata_b); end
  endtask

  task automatic test_busy_write();
    int n, zero_bad;
    write_a(4'd7, 16'h0707);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    rsel = {4'd7, 4'd5};
    n = 0; zero_bad = 0;
    while (busy && n < 100) begin
      n++;
      we = 1'b0; clr = 1'b0;
      if (n == 3) begin we = 1'b1; wsel = 4'd7; wdata = 16'h7777; end
      if (n == 10) clr = 1'b1;
      if (n == 12) begin we = 1'b1; wsel = 4'd2; wdata = 16'h2222; end
      #1;
      if (rdata !== 32'h0 || wcur !== 16'h0) zero_bad++;
      tick();
    end
    we = 1'b0; clr = 1'b0;
    total++;
    if (n !== 15) begin bad++; $display("FAIL busy_len: got %0d cycles, want 15", n); end
    total++;
    if (zero_bad !== 0) begin bad++; $display("FAIL busy_zero: %0d nonzero cycles, want 0", zero_bad); end
    rsel = {4'd2, 4'd7};
    #1;
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL busy_write_dropped: got %h want 00000000", rdata); end
  endtask

  task automatic test_clr_and_we();
    clr = 1'b1; we = 1'b1; wsel = 4'd4; wdata = 16'h4444;
    tick();
    clr = 1'b0; we = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL clr_we_busy: busy=%b want 1", busy); end
    for (int i = 0; i < 100 && busy; i++) tick();
    rsel = {4'd0, 4'd4};
    #1;
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL clr_we_zeroed: got %h want 00000000", rdata); end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    write_a(4'd5, 16'h5555);
    write_a(4'd9, 16'h9999);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n = 0;
    while (busy && n < 5) begin n++; tick(); end
    total++;
    if (n !== 5) begin bad++; $display("FAIL mid_pre: got %0d busy cycles, want 5", n); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 100 && busy; i++) begin n++; tick(); end
    total++;
    if (n !== 15) begin bad++; $display("FAIL mid_restart: got %0d cycles, want 15", n); end
    rsel = {4'd9, 4'd5};
    #1;
    total++;
    if (rdata !== 32'h0) begin bad++; $display("FAIL mid_zeroed: got %h want 00000000", rdata); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_same_cycle();
    test_sweep();
    test_busy_write();
    test_clr_and_we();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
